sdp_ram_param: RTL and testbench
================================

SDP_RAM_PARAM -- requirements
Module: sdp_ram_param

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 48: word width; SHALL be a multiple of LANE_W.
- LANE_W, 16: write-enable lane width; LANES = DATA_W/LANE_W.
- ADDR_W, 7: address width; DEPTH = 2**ADDR_W.
- OUT_REG, 1: 0 gives 1-cycle read latency; 1 gives 2-cycle read latency through the output register.
- INIT_CLEAR, 1: 1 zero-fills the array after reset.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- clr, in, 1: one-cycle pulse that starts a zero-fill of the array.
- cea, in, 1: write enable.
- ada, in, ADDR_W: write address.
- din, in, DATA_W: write data.
- wbe, in, LANES: per-lane write enable; lane i covers din[i*LANE_W +: LANE_W].
- ceb, in, 1: read enable.
- adb, in, ADDR_W: read address.
- oce, in, 1: output-register clock enable; used only when OUT_REG=1.
- dout, out, DATA_W: read data.
- dout_vld, out, 1: dout holds valid read data.
- init_busy, out, 1: zero-fill in progress.

Function
REQ-003 The block SHALL implement a controller FSM with states CLEAR and READY.
REQ-004 On reset, the FSM SHALL enter CLEAR with clear pointer 0 if INIT_CLEAR=1, otherwise READY.
REQ-005 In CLEAR, the block SHALL write all-zero words to the array at the pointer, one address per cycle, incrementing the pointer.
REQ-006 After writing address DEPTH-1, the FSM SHALL go to READY.
REQ-007 The pointer SHALL NOT wrap within a clear sequence.
REQ-008 A clear SHALL take exactly DEPTH cycles; init_busy SHALL be 1 in every CLEAR cycle and 0 in READY.
REQ-009 clr=1 in READY SHALL enter CLEAR with pointer 0 on the next cycle.
REQ-010 clr=1 in CLEAR SHALL restart the pointer at 0.
REQ-011 In CLEAR, cea and ceb SHALL be ignored: no user write occurs and no read is issued.
REQ-012 In READY, cea=1 SHALL write lane i of din to mem[ada] only for lanes where wbe[i]=1; other lanes SHALL keep their old contents.
REQ-013 cea=1 with wbe all zero SHALL leave memory unchanged.
REQ-014 In READY, ceb=1 SHALL load stage-1 register q1 with mem[adb] on the next edge and set v1=1; ceb=0 SHALL hold q1 and clear v1.
REQ-015 If the read and write are to the same address in the same cycle (cea=ceb=1, ada=adb), q1 SHALL take din on enabled lanes and the old memory contents on the other lanes (write-first forwarding).
REQ-016 When OUT_REG=0: dout=q1 and dout_vld=v1; latency is 1 cycle from ceb to dout.
REQ-017 When OUT_REG=1: on each edge with oce=1, q2<=q1 and v2<=v1; with oce=0, q2 and v2 SHALL hold. dout=q2 and dout_vld=v2; latency is 2 cycles with oce held at 1.
REQ-018 Back-to-back reads SHALL sustain one result per cycle with no bubbles.
REQ-019 Addresses SHALL be unsigned in 0..DEPTH-1; no out-of-range case exists.

Reset
REQ-020 On reset, dout, q1 and q2 SHALL be 0, and dout_vld, v1 and v2 SHALL be 0.
REQ-021 On reset, the state and init_busy SHALL be as in REQ-004 and REQ-008 (init_busy=1 when INIT_CLEAR=1).
REQ-022 Reset SHALL NOT otherwise alter array contents; zeroing happens only through CLEAR.
REQ-023 Reset asserted during CLEAR SHALL abort the sequence and restart it at address 0 once reset deasserts.
REQ-024 A read in flight when reset is asserted SHALL be discarded, with dout_vld=0 in the cycle after reset.

Verification
REQ-025 The bench SHALL cover these directed scenarios (stimulus -> required response), using defaults unless stated:
- Reset for 2 cycles, then idle -> init_busy=1 for exactly 128 cycles, then 0; reading each of addresses 0..127 returns 0.
- Write 0x123456789ABC to ada=5 with wbe=3'b111; later ceb=1, adb=5 with oce=1 -> dout=0x123456789ABC and dout_vld=1 exactly 2 cycles after ceb.
- Then write din=0xFFFF00000000 to address 5 with wbe=3'b100, and read address 5 -> dout=0xFFFF56789ABC.
- Same-cycle cea=ceb=1, ada=adb=9, wbe=3'b010, din=0x0000AAAA0000, mem[9]=0 -> dout=0x0000AAAA0000.
- OUT_REG=1; read address 5, then hold oce=0 for 3 cycles -> dout and dout_vld frozen until oce returns to 1, and no data is lost.
- Assert reset at clear pointer 60, release -> clear restarts at 0, init_busy=1 for a further 128 cycles, and a cea issued during that time leaves no effect.

Source files
------------

// File: rtl/sdp_ram_param.sv
// Simple dual-port RAM with per-lane write enables, write-first forwarding,
// optional output register and a zero-fill controller (CLEAR/READY).
module sdp_ram_param #(
    parameter int DATA_W     = 48,
    parameter int LANE_W     = 16,
    parameter int ADDR_W     = 7,
    parameter int OUT_REG    = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       cea,
    input  logic [ADDR_W-1:0]          ada,
    input  logic [DATA_W-1:0]          din,
    input  logic [DATA_W/LANE_W-1:0]   wbe,
    input  logic                       ceb,
    input  logic [ADDR_W-1:0]          adb,
    input  logic                       oce,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_vld,
    output logic                       init_busy
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_q1;
    logic                r_v1;
    logic [DATA_W-1:0]   w_rd_fwd;
    logic                w_clr_wr;
    logic                w_user_wr;
    logic                w_user_rd;

    // User ports are only honoured in READY; the clear walk owns the array otherwise.
    assign w_clr_wr  = !reset && (r_state == ST_CLEAR);
    assign w_user_wr = !reset && (r_state == ST_READY) && cea;
    assign w_user_rd = !reset && (r_state == ST_READY) && ceb;

    assign init_busy = (r_state == ST_CLEAR);

    // Controller: walks the clear pointer 0..DEPTH-1 once, restarting on clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            r_ptr   <= '0;
        end else if (r_state == ST_CLEAR) begin
            if (clr) begin
                r_ptr <= '0;
            end else if (&r_ptr) begin
                r_state <= ST_READY;
                r_ptr   <= '0;
            end else begin
                r_ptr <= r_ptr + 1'b1;
            end
        end else if (clr) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end
    end

    // Array write: zero word during clear, lane-masked user write when ready.
    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            r_mem[r_ptr] <= '0;
        end else if (w_user_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    r_mem[ada][i*LANE_W +: LANE_W] <= din[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read word with same-address write data merged in on the enabled lanes.
    always_comb begin
        w_rd_fwd = r_mem[adb];
        if (cea && (ada == adb)) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) begin
                    w_rd_fwd[i*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Stage 1 read register: data holds when idle, valid tracks the issued read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q1 <= '0;
            r_v1 <= 1'b0;
        end else if (w_user_rd) begin
            r_q1 <= w_rd_fwd;
            r_v1 <= 1'b1;
        end else begin
            r_v1 <= 1'b0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_W-1:0] r_q2;
            logic              r_v2;

            // Stage 2 output register, stalled as a unit by oce.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q2 <= '0;
                    r_v2 <= 1'b0;
                end else if (oce) begin
                    r_q2 <= r_q1;
                    r_v2 <= r_v1;
                end
            end

            assign dout     = r_q2;
            assign dout_vld = r_v2;
        end else begin : g_noreg
            logic w_unused_oce;
            assign w_unused_oce = oce;
            assign dout         = r_q1;
            assign dout_vld     = r_v1;
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_param.sv
// Directed bench for sdp_ram_param with default parameters (OUT_REG=1, 128 x 48).
module tb_sdp_ram_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        cea = 1'b0;
    logic [6:0]  ada = '0;
    logic [47:0] din = '0;
    logic [2:0]  wbe = '0;
    logic        ceb = 1'b0;
    logic [6:0]  adb = '0;
    logic        oce = 1'b1;
    wire  [47:0] dout;
    wire         dout_vld;
    wire         init_busy;

    int n_checks = 0;
    int n_fail   = 0;

    sdp_ram_param dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .cea       (cea),
        .ada       (ada),
        .din       (din),
        .wbe       (wbe),
        .ceb       (ceb),
        .adb       (adb),
        .oce       (oce),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [47:0] d, input logic [2:0] be);
        cea = 1'b1; ada = a; din = d; wbe = be;
        tick();
        cea = 1'b0; wbe = '0;
    endtask

    task automatic do_read(input logic [6:0] a, output logic [47:0] d, output logic v);
        ceb = 1'b1; adb = a; oce = 1'b1;
        tick();
        ceb = 1'b0;
        tick();
        d = dout;
        v = dout_vld;
    endtask

    task automatic test_reset;
        int n;
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (dout !== 48'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", dout); end
        n_checks++;
        if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", dout_vld); end
        n_checks++;
        if (init_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", init_busy); end
        reset = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 128) begin n_fail++; $display("FAIL init_clear_len: got %0d cycles expected 128", n); end
        // Sweep every address back to back; each must read as zero.
        for (int i = 0; i <= 128; i++) begin
            ceb = (i < 128);
            adb = 7'(i);
            oce = 1'b1;
            tick();
            if (i >= 1) begin
                n_checks++;
                if ({dout_vld, dout} !== {1'b1, 48'h0}) begin
                    n_fail++;
                    $display("FAIL clear_read[%0d]: got vld=%b %h expected vld=1 0", i - 1, dout_vld, dout);
                end
            end
        end
        ceb = 1'b0;
        tick();
    endtask

    task automatic test_full_write_latency;
        do_write(7'd5, 48'h123456789ABC, 3'b111);
        ceb = 1'b1; adb = 7'd5; oce = 1'b1;
        tick();
        ceb = 1'b0;
        n_checks++;
        if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL latency_early_vld: got %b expected 0", dout_vld); end
        tick();
        n_checks++;
        if ({dout_vld, dout} !== {1'b1, 48'h123456789ABC}) begin
            n_fail++;
            $display("FAIL full_write_read: got vld=%b %h expected vld=1 123456789abc", dout_vld, dout);
        end
    endtask

    task automatic test_lane_write;
        logic [47:0] d;
        logic        v;
        do_write(7'd5, 48'hFFFF00000000, 3'b100);
        do_read(7'd5, d, v);
        n_checks++;
        if ({v, d} !== {1'b1, 48'hFFFF56789ABC}) begin
            n_fail++;
            $display("FAIL lane_write: got vld=%b %h expected vld=1 ffff56789abc", v, d);
        end
    endtask

    task automatic test_wbe_zero;
        logic [47:0] d;
        logic        v;
        do_write(7'd5, 48'hFFFFFFFFFFFF, 3'b000);
        do_read(7'd5, d, v);
        n_checks++;
        if (d !== 48'hFFFF56789ABC) begin n_fail++; $display("FAIL wbe_zero: got %h expected ffff56789abc", d); end
    endtask

    task automatic test_forward;
        logic [47:0] d;
        logic        v;
        cea = 1'b1; ceb = 1'b1; ada = 7'd9; adb = 7'd9; wbe = 3'b010; din = 48'h0000AAAA0000;
        tick();
        cea = 1'b0; ceb = 1'b0; wbe = '0;
        tick();
        n_checks++;
        if ({dout_vld, dout} !== {1'b1, 48'h0000AAAA0000}) begin
            n_fail++;
            $display("FAIL forward_zero_old: got vld=%b %h expected vld=1 0000aaaa0000", dout_vld, dout);
        end
        // Forwarding over a non-zero old word must keep the untouched lanes.
        cea = 1'b1; ceb = 1'b1; ada = 7'd5; adb = 7'd5; wbe = 3'b001; din = 48'h000000001111;
        tick();
        cea = 1'b0; ceb = 1'b0; wbe = '0;
        tick();
        n_checks++;
        if (dout !== 48'hFFFF56781111) begin n_fail++; $display("FAIL forward_mixed: got %h expected ffff56781111", dout); end
        do_read(7'd9, d, v);
        n_checks++;
        if (d !== 48'h0000AAAA0000) begin n_fail++; $display("FAIL forward_stored: got %h expected 0000aaaa0000", d); end
    endtask

    task automatic test_back_to_back;
        logic [47:0] vals [4];
        vals[0] = 48'h111122223333;
        vals[1] = 48'h444455556666;
        vals[2] = 48'h777788889999;
        vals[3] = 48'hAAAABBBBCCCC;
        for (int i = 0; i < 4; i++) do_write(7'(20 + i), vals[i], 3'b111);
        oce = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            ceb = (i < 4);
            adb = 7'(20 + i);
            tick();
            if (i >= 1) begin
                n_checks++;
                if ({dout_vld, dout} !== {1'b1, vals[i-1]}) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got vld=%b %h expected vld=1 %h", i - 1, dout_vld, dout, vals[i-1]);
                end
            end
        end
        ceb = 1'b0;
        tick();
        n_checks++;
        if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_vld: got %b expected 0", dout_vld); end
    endtask

    task automatic test_oce_stall;
        oce = 1'b1; ceb = 1'b1; adb = 7'd9;
        tick();
        adb = 7'd5;
        tick();
        oce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({dout_vld, dout} !== {1'b1, 48'h0000AAAA0000}) begin
                n_fail++;
                $display("FAIL oce_hold[%0d]: got vld=%b %h expected vld=1 0000aaaa0000", i, dout_vld, dout);
            end
        end
        oce = 1'b1; ceb = 1'b0;
        tick();
        n_checks++;
        if ({dout_vld, dout} !== {1'b1, 48'hFFFF56781111}) begin
            n_fail++;
            $display("FAIL oce_resume: got vld=%b %h expected vld=1 ffff56781111", dout_vld, dout);
        end
        tick();
        n_checks++;
        if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL oce_tail_vld: got %b expected 0", dout_vld); end
    endtask

    task automatic test_reset_midclear;
        int          n;
        logic [47:0] d;
        logic        v;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (init_busy !== 1'b1) begin n_fail++; $display("FAIL clr_enter: got %b expected 1", init_busy); end
        for (int i = 0; i < 60; i++) tick();
        n_checks++;
        if (init_busy !== 1'b1) begin n_fail++; $display("FAIL clr_at_60: got %b expected 1", init_busy); end
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 400) begin
            cea = (n == 10); ada = 7'd2; din = 48'hFFFFFFFFFFFF; wbe = 3'b111;
            ceb = (n == 10); adb = 7'd5;
            tick();
            n++;
            if (n == 12) begin
                n_checks++;
                if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL clear_read_ignored: got vld=%b expected 0", dout_vld); end
            end
        end
        cea = 1'b0; ceb = 1'b0; wbe = '0;
        n_checks++;
        if (n !== 128) begin n_fail++; $display("FAIL restart_clear_len: got %0d cycles expected 128", n); end
        do_read(7'd2, d, v);
        n_checks++;
        if ({v, d} !== {1'b1, 48'h0}) begin n_fail++; $display("FAIL clear_write_ignored: got vld=%b %h expected vld=1 0", v, d); end
        do_read(7'd5, d, v);
        n_checks++;
        if (d !== 48'h0) begin n_fail++; $display("FAIL cleared_addr5: got %h expected 0", d); end
    endtask

    task automatic test_reset_inflight;
        int n;
        oce = 1'b1; ceb = 1'b1; adb = 7'd20;
        tick();
        ceb = 1'b0;
        reset = 1'b1;
        tick();
        n_checks++;
        if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL inflight_vld0: got %b expected 0", dout_vld); end
        reset = 1'b0;
        tick();
        n_checks++;
        if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL inflight_vld1: got %b expected 0", dout_vld); end
        n = 1;
        while (init_busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 128) begin n_fail++; $display("FAIL inflight_clear_len: got %0d cycles expected 128", n); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_write_latency();
        test_lane_write();
        test_wbe_zero();
        test_forward();
        test_back_to_back();
        test_oce_stall();
        test_reset_midclear();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
